id_frame_rx: RTL and testbench

- Upstream receiver for the ID access-check stage.
- Assembles a serially delivered credential ID into a parallel word and checks framing and, optionally, parity.
- Presents the word on id_dynamic with a one-cycle req_valid strobe; the access-check stage compares it against id_fixed.
- Also counts malformed frames for software diagnostics.

---
 rtl/id_frame_rx.sv | 177 +++++++++++++++++
 tb/tb_id_frame_rx.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_frame_rx.sv
`default_nettype none
// ============================================================================
// Module      : id_frame_rx
// Description : Serial credential-ID frame receiver. Shifts in ID_WIDTH bits
//               MSB first after a bit_start marker, presents the assembled
//               word on id_dynamic with a one-cycle req_valid strobe, and
//               flags timeout / abort (and optionally parity) errors with a
//               one-cycle frame_err pulse and a saturating error counter.
//               Optional parity bit after the data bits is compiled in with
//               the macro ID_FRAME_RX_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module id_frame_rx #(
    parameter int ID_WIDTH       = 32,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int PARITY_ODD     = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                bit_start,
    input  logic                bit_valid,
    input  logic                bit_data,
    output logic [ID_WIDTH-1:0] id_dynamic,
    output logic                req_valid,
    output logic                frame_err,
    output logic                busy,
    output logic [7:0]          err_count
);

    localparam int c_bit_cnt_w = (ID_WIDTH > 1) ? $clog2(ID_WIDTH) : 1;
    localparam int c_to_cnt_w  = $clog2(TIMEOUT_CYCLES);
    localparam logic [c_bit_cnt_w-1:0] c_last_bit = c_bit_cnt_w'(ID_WIDTH - 1);
    localparam logic [c_to_cnt_w-1:0]  c_to_last  = c_to_cnt_w'(TIMEOUT_CYCLES - 1);

`ifdef ID_FRAME_RX_PARITY_EN
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2
    } state_t;
    localparam logic c_par_odd = (PARITY_ODD != 0);
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1
    } state_t;
`endif

    state_t                  r_state;
    state_t                  w_state_nx;
    logic [ID_WIDTH-1:0]     r_shreg;
    logic [ID_WIDTH-1:0]     w_shreg_nx;
    logic [ID_WIDTH-1:0]     w_shift_val;
    logic [c_bit_cnt_w-1:0]  r_bit_cnt;
    logic [c_bit_cnt_w-1:0]  w_bit_cnt_nx;
    logic [c_to_cnt_w-1:0]   r_to_cnt;
    logic [c_to_cnt_w-1:0]   w_to_cnt_nx;
    logic [ID_WIDTH-1:0]     r_id;
    logic [ID_WIDTH-1:0]     w_id_nx;
    logic                    r_req_valid;
    logic                    r_frame_err;
    logic [7:0]              r_err_count;
    logic                    w_done;
    logic                    w_err;

`ifndef ID_FRAME_RX_PARITY_EN
    // Without parity the shift register MSB and parity sense are never read.
    logic [1:0] w_unused_bits;
    assign w_unused_bits = {r_shreg[ID_WIDTH-1], (PARITY_ODD != 0)};
`endif

    assign w_shift_val = {r_shreg[ID_WIDTH-2:0], bit_data};

    // Next-state, datapath and event decode; bit_start has priority everywhere.
    always_comb begin
        w_state_nx   = r_state;
        w_shreg_nx   = r_shreg;
        w_bit_cnt_nx = r_bit_cnt;
        w_to_cnt_nx  = r_to_cnt;
        w_id_nx      = r_id;
        w_done       = 1'b0;
        w_err        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bit_start) begin
                    w_state_nx   = ST_SHIFT;
                    w_bit_cnt_nx = '0;
                    w_to_cnt_nx  = '0;
                end
            end
            ST_SHIFT: begin
                if (bit_start) begin
                    // Abort and restart directly into a fresh frame.
                    w_err        = 1'b1;
                    w_bit_cnt_nx = '0;
                    w_to_cnt_nx  = '0;
                end else if (bit_valid) begin
                    w_shreg_nx  = w_shift_val;
                    w_to_cnt_nx = '0;
                    if (r_bit_cnt == c_last_bit) begin
`ifdef ID_FRAME_RX_PARITY_EN
                        w_state_nx = ST_PARITY;
`else
                        w_state_nx = ST_IDLE;
                        w_id_nx    = w_shift_val;
                        w_done     = 1'b1;
`endif
                    end else begin
                        w_bit_cnt_nx = r_bit_cnt + 1'b1;
                    end
                end else if (r_to_cnt == c_to_last) begin
                    w_err      = 1'b1;
                    w_state_nx = ST_IDLE;
                end else begin
                    w_to_cnt_nx = r_to_cnt + 1'b1;
                end
            end
`ifdef ID_FRAME_RX_PARITY_EN
            ST_PARITY: begin
                if (bit_start) begin
                    w_err        = 1'b1;
                    w_state_nx   = ST_SHIFT;
                    w_bit_cnt_nx = '0;
                    w_to_cnt_nx  = '0;
                end else if (bit_valid) begin
                    w_state_nx = ST_IDLE;
                    if (bit_data == ((^r_shreg) ^ c_par_odd)) begin
                        w_id_nx = r_shreg;
                        w_done  = 1'b1;
                    end else begin
                        w_err = 1'b1;
                    end
                end else if (r_to_cnt == c_to_last) begin
                    w_err      = 1'b1;
                    w_state_nx = ST_IDLE;
                end else begin
                    w_to_cnt_nx = r_to_cnt + 1'b1;
                end
            end
`endif
            default: w_state_nx = ST_IDLE;
        endcase
    end

    // State, datapath and registered output strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_shreg     <= '0;
            r_bit_cnt   <= '0;
            r_to_cnt    <= '0;
            r_id        <= '0;
            r_req_valid <= 1'b0;
            r_frame_err <= 1'b0;
            r_err_count <= 8'd0;
        end else begin
            r_state     <= w_state_nx;
            r_shreg     <= w_shreg_nx;
            r_bit_cnt   <= w_bit_cnt_nx;
            r_to_cnt    <= w_to_cnt_nx;
            r_id        <= w_id_nx;
            r_req_valid <= w_done;
            r_frame_err <= w_err;
            if (w_err && (r_err_count != 8'hFF)) begin
                r_err_count <= r_err_count + 8'd1;
            end
        end
    end

    assign id_dynamic = r_id;
    assign req_valid  = r_req_valid;
    assign frame_err  = r_frame_err;
    assign busy       = (r_state != ST_IDLE);
    assign err_count  = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_id_frame_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_frame_rx
// Description : Self-checking bench for id_frame_rx. A frame-level reference
//               model (bit queue, idle-run counter, popcount parity) predicts
//               every output each cycle; directed scenarios pin key values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_id_frame_rx;

    localparam int W     = 32;
    localparam int T     = 1024;
    localparam int P_ODD = 0;
`ifdef ID_FRAME_RX_PARITY_EN
    localparam int FRAME_LEN = W + 1;
`else
    localparam int FRAME_LEN = W;
`endif

    logic         clk;
    logic         rst_n;
    logic         bit_start;
    logic         bit_valid;
    logic         bit_data;
    logic [W-1:0] id_dynamic;
    logic         req_valid;
    logic         frame_err;
    logic         busy;
    logic [7:0]   err_count;

    int vectors;
    int miscompares;

    id_frame_rx #(
        .ID_WIDTH       (W),
        .TIMEOUT_CYCLES (T),
        .PARITY_ODD     (P_ODD)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bit_start  (bit_start),
        .bit_valid  (bit_valid),
        .bit_data   (bit_data),
        .id_dynamic (id_dynamic),
        .req_valid  (req_valid),
        .frame_err  (frame_err),
        .busy       (busy),
        .err_count  (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (frame level) ----------------
    logic [W-1:0] m_id;
    bit           m_req;
    bit           m_err;
    bit           m_busy;
    int           m_cnt;
    int           idle_run;
    logic         q[$];
    logic [W-1:0] m_word;
    int           m_ones;
    bit           m_ev_err;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_id = '0; m_req = 0; m_err = 0; m_busy = 0; m_cnt = 0;
            idle_run = 0; q.delete();
        end else begin
            m_req    = 0;
            m_ev_err = 0;
            if (bit_start) begin
                if (m_busy) m_ev_err = 1;
                m_busy   = 1;
                q.delete();
                idle_run = 0;
            end else if (m_busy) begin
                if (bit_valid) begin
                    q.push_back(bit_data);
                    idle_run = 0;
                    if (q.size() == FRAME_LEN) begin
                        m_busy = 0;
                        for (int i = 0; i < W; i++) m_word[W-1-i] = q[i];
`ifdef ID_FRAME_RX_PARITY_EN
                        m_ones = $countones(m_word) + int'(q[W]);
                        if ((m_ones % 2) == P_ODD) begin
                            m_req = 1; m_id = m_word;
                        end else begin
                            m_ev_err = 1;
                        end
`else
                        m_req = 1; m_id = m_word;
`endif
                    end
                end else begin
                    idle_run++;
                    if (idle_run == T) begin
                        m_ev_err = 1;
                        m_busy   = 0;
                    end
                end
            end
            m_err = m_ev_err;
            if (m_ev_err && m_cnt < 255) m_cnt++;
        end
    end

    // Compare every cycle, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("req_valid", {31'd0, req_valid}, {31'd0, m_req});
            chk("frame_err", {31'd0, frame_err}, {31'd0, m_err});
            chk("busy", {31'd0, busy}, {31'd0, m_busy});
            chk("err_count", {24'd0, err_count}, m_cnt);
            chk("id_dynamic", id_dynamic, m_id);
            chk("req_err_exclusive", {31'd0, req_valid & frame_err}, 32'd0);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic s, input logic v, input logic d);
        bit_start = s; bit_valid = v; bit_data = d;
        @(posedge clk); #1;
        bit_start = 0; bit_valid = 0; bit_data = 0;
    endtask

    task automatic send_bits(input logic [W-1:0] w);
        for (int i = W - 1; i >= 0; i--) step(0, 1, w[i]);
    endtask

    task automatic send_frame(input logic [W-1:0] w, input logic p);
        step(1, 0, 0);
        send_bits(w);
`ifdef ID_FRAME_RX_PARITY_EN
        step(0, 1, p);
`else
        if (p === 1'bx) step(0, 0, 0);
`endif
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_id"}, id_dynamic, 32'd0);
        chk({tag, "_req"}, {31'd0, req_valid}, 32'd0);
        chk({tag, "_err"}, {31'd0, frame_err}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_cnt"}, {24'd0, err_count}, 32'd0);
    endtask

    int           exp_errs;
    logic [W-1:0] w;
    logic         p;
    int           sel;

    initial begin
        vectors = 0; miscompares = 0; exp_errs = 0;
        rst_n = 1; bit_start = 0; bit_valid = 0; bit_data = 0;
        #3 rst_n = 0;
        #1 check_reset_outputs("reset");
        @(posedge clk); @(posedge clk); #1 rst_n = 1;

        // bit_valid in IDLE is ignored
        step(0, 1, 1);
        chk("idle_ignore_busy", {31'd0, busy}, 32'd0);

        // Good frame 0xDEADBEEF (popcount 24, even parity bit 0)
        send_frame(32'hDEADBEEF, 1'b0);
        chk("good_req", {31'd0, req_valid}, 32'd1);
        chk("good_id", id_dynamic, 32'hDEADBEEF);
        chk("good_busy", {31'd0, busy}, 32'd0);
        chk("good_err", {31'd0, frame_err}, 32'd0);
        step(0, 0, 0);
        chk("good_req_once", {31'd0, req_valid}, 32'd0);

`ifdef ID_FRAME_RX_PARITY_EN
        // Bad parity: error pulse, no update
        send_frame(32'hDEADBEEF, 1'b1);
        exp_errs++;
        chk("par_err", {31'd0, frame_err}, 32'd1);
        chk("par_req", {31'd0, req_valid}, 32'd0);
        chk("par_cnt", {24'd0, err_count}, exp_errs);
        chk("par_id", id_dynamic, 32'hDEADBEEF);
`endif

        // Timeout after 10 bits: error exactly after T bit-less cycles
        step(1, 0, 0);
        for (int i = 0; i < 10; i++) step(0, 1, 1'($urandom_range(0, 1)));
        repeat (T - 1) step(0, 0, 0);
        chk("to_not_early", {31'd0, frame_err}, 32'd0);
        chk("to_busy_before", {31'd0, busy}, 32'd1);
        step(0, 0, 0);
        exp_errs++;
        chk("to_err", {31'd0, frame_err}, 32'd1);
        chk("to_busy_after", {31'd0, busy}, 32'd0);
        chk("to_cnt", {24'd0, err_count}, exp_errs);

        // Abort after 20 bits, then frame 0x00000001 with parity bit 1
        step(1, 0, 0);
        for (int i = 0; i < 20; i++) step(0, 1, 1'($urandom_range(0, 1)));
        send_frame(32'h00000001, 1'b1);
        exp_errs++;
        chk("abort_req", {31'd0, req_valid}, 32'd1);
        chk("abort_id", id_dynamic, 32'h00000001);
        chk("abort_cnt", {24'd0, err_count}, exp_errs);

        // Randomized traffic checked by the model
        for (int it = 0; it < 40; it++) begin
            sel = $urandom_range(0, 9);
            if (sel <= 5) begin
                w = $urandom;
                p = (^w) ^ 1'(P_ODD) ^ ($urandom_range(0, 3) == 0);
                step(1, $urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)));
                for (int i = 0; i < FRAME_LEN; i++) begin
                    repeat ($urandom_range(0, 2)) step(0, 0, 1'($urandom_range(0, 1)));
                    step(0, 1, (i < W) ? w[W-1-i] : p);
                end
            end else if (sel <= 7) begin
                step(1, 0, 0);
                repeat ($urandom_range(1, 30)) step(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end else begin
                repeat ($urandom_range(1, 5)) step(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end
        end

        // Saturation: 260 aborts pushes the counter past 255
        step(1, 0, 0);
        repeat (260) step(1, 0, 0);
        chk("sat_cnt", {24'd0, err_count}, 32'd255);
        repeat (3) step(1, 0, 0);
        chk("sat_hold", {24'd0, err_count}, 32'd255);

        // bit_start with bit_valid in SHIFT: abort, bit discarded
        w = 32'h12345678;
        step(1, 1, 1);
        send_bits(w);
`ifdef ID_FRAME_RX_PARITY_EN
        step(0, 1, (^w) ^ 1'(P_ODD));
`endif
        chk("same_cycle_shift_id", id_dynamic, 32'h12345678);
        chk("same_cycle_shift_req", {31'd0, req_valid}, 32'd1);

        // bit_start with bit_valid in IDLE: bit discarded
        step(0, 0, 0);
        w = 32'h0F0F0F0F;
        step(1, 1, 1);
        send_bits(w);
`ifdef ID_FRAME_RX_PARITY_EN
        step(0, 1, (^w) ^ 1'(P_ODD));
`endif
        chk("same_cycle_idle_id", id_dynamic, 32'h0F0F0F0F);

        // Asynchronous reset mid-frame, then a clean frame
        step(1, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 1, 1);
        #2 rst_n = 0;
        #1 check_reset_outputs("midrst");
        @(posedge clk); #1 rst_n = 1;
        chk("midrst_no_err", {31'd0, frame_err}, 32'd0);
        send_frame(32'hA5A5A5A5, 1'b0);
        chk("post_rst_req", {31'd0, req_valid}, 32'd1);
        chk("post_rst_id", id_dynamic, 32'hA5A5A5A5);
        chk("post_rst_err", {31'd0, frame_err}, 32'd0);
        step(0, 0, 0);
        step(0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
